sync_fifo_reader: RTL and testbench

- Read-side drain engine for the team's synchronous FIFO.
- Watches the FIFO's empty flag, issues read strobes and absorbs the FIFO's one-cycle read latency.
- Presents the words downstream on a valid/ready stream with full throughput and backpressure.
- Sits between the FIFO read port and any downstream consumer; a small 2-entry output buffer carries data across the read latency.

---
 rtl/sync_fifo_reader.sv | 69 ++++++
 tb/tb_sync_fifo_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// Read-side drain engine for the synchronous FIFO.
// Absorbs the one-cycle read latency with a 2-entry output buffer.
module sync_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  logic [WIDTH-1:0] r_mem [2];
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_head;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pop;
  logic             w_tail;
  logic [1:0]       w_occ_nxt;

  assign w_pop     = r_valid & out_ready;
  assign w_occ_nxt = r_occ + {1'b0, r_inflight}
                   - {1'b0, w_pop};
  // occ + inflight never exceeds 2, so a capture
  // always finds occ at 0 or 1
  assign w_tail    = r_head ^ (r_occ != 2'd0);

  assign fifo_rd_en = rst & en & ~fifo_empty
                    & (w_occ_nxt < 2'd2);

  assign out_valid = r_valid;
  assign out_data  = r_mem[r_head];
  assign busy      = r_inflight | r_valid;
  assign word_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[w_tail] <= fifo_rd_data;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      r_occ      <= w_occ_nxt;
      r_valid    <= (w_occ_nxt != 2'd0);
      r_inflight <= fifo_rd_en;
    end
  end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: FIFO model plus
// a scoreboard of words expected downstream.
module tb_sync_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [3:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];

  int         rd_cnt      = 0;
  int         delivered   = 0;
  int         outstanding = 0;
  logic [3:0] exp_cnt     = 4'd0;
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_data   = 8'h00;

  sync_fifo_reader #(
    .WIDTH(8),
    .CNT_W(4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // FIFO model: data one cycle after the strobe
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0)
      fifo_rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < outstanding; i++)
        if (exp_q.size() != 0)
          void'(exp_q.pop_front());
      outstanding = 0;
      exp_cnt     = 4'd0;
      prev_stall  = 1'b0;
    end else begin
      chk("busy", 32'(busy),
          32'(outstanding != 0));
      chk("word_cnt", 32'(word_cnt),
          32'(exp_cnt));
      if (fifo_rd_en)
        chk("rd_when_empty",
            32'(fifo_empty), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data),
            32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("sb_extra", 32'(exp_q.size()), 32'd1);
        else
          chk("sb_data", 32'(out_data),
              32'(exp_q.pop_front()));
        delivered++;
        exp_cnt = exp_cnt + 4'd1;
      end
      outstanding = outstanding
                  + int'(fifo_rd_en)
                  - int'(out_valid && out_ready);
      chk("no_overflow",
          32'(outstanding <= 2), 32'd1);
      if (fifo_rd_en) rd_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int r0;
    int d0;
    int i;
    rst       = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;

    // reset hold with data waiting
    for (int k = 1; k <= 5; k++) push(8'(k));
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt", 32'(word_cnt), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    d0  = delivered;
    @(negedge clk);
    chk("rel_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("lat_n2_data", 32'(out_data), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("stream_dlv", 32'(delivered - d0), 32'd5);
    chk("stream_cnt", 32'(word_cnt), 32'd5);
    chk("stream_busy", 32'(busy), 32'd0);

    // backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    r0 = rd_cnt;
    for (int k = 1; k <= 4; k++) push(8'(k));
    repeat (8) @(posedge clk);
    #1;
    chk("bp_reads", 32'(rd_cnt - r0), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'd1);
    d0 = delivered;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_dlv", 32'(delivered - d0), 32'd4);
    chk("bp_sb_left", 32'(exp_q.size()), 32'd0);

    // en toggle
    r0 = rd_cnt;
    d0 = delivered;
    for (int k = 1; k <= 10; k++) push(8'(k));
    i = 0;
    while (rd_cnt - r0 < 3 && i < 40) begin
      @(posedge clk);
      i++;
    end
    chk("en_wait", 32'(rd_cnt - r0), 32'd3);
    #1;
    en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("en_off_reads", 32'(rd_cnt - r0), 32'd3);
    chk("en_off_dlv", 32'(delivered - d0), 32'd3);
    en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("en_on_reads", 32'(rd_cnt - r0), 32'd10);
    chk("en_on_dlv", 32'(delivered - d0), 32'd10);
    chk("en_sb_left", 32'(exp_q.size()), 32'd0);

    // reset with a word buffered and one in flight
    out_ready = 1'b0;
    for (int k = 41; k <= 46; k++) push(8'(k));
    r0 = rd_cnt;
    i  = 0;
    while (rd_cnt - r0 < 2 && i < 40) begin
      @(posedge clk);
      i++;
    end
    chk("mr_wait", 32'(rd_cnt - r0), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mr_cnt", 32'(word_cnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    d0        = delivered;
    repeat (12) @(posedge clk);
    #1;
    chk("mr_dlv", 32'(delivered - d0), 32'd4);
    chk("mr_sb_left", 32'(exp_q.size()), 32'd0);

    // counter wrap at CNT_W=4
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 17; k++) push(8'(50 + k));
    repeat (25) @(posedge clk);
    #1;
    chk("wrap_cnt", 32'(word_cnt), 32'd1);
    chk("wrap_sb_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
